alu_execute_unit: RTL and testbench
===================================

Name: alu_execute_unit

Overview:
- Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU decoder and performs the selected operation on two operands.
- Single-cycle ops (add, sub, shifts, logic) complete in one state step.
- Mult/div run as iterative shift-add / restoring-divide engines over WIDTH cycles, writing HI/LO.
- A start/busy/done handshake lets the multi-cycle control FSM stall the datapath until the result is ready.

Parameters:
- WIDTH, 32, operand and result width (≥ 4, power of two).
- SHAMT_W, 5, shift-amount bits taken from Operand_b (must equal log2(WIDTH)).

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- Start  input  1  request; accepted only when Busy=0.
- ALU_control  input  4  operation code; sampled on accept.
- Operand_a  input  WIDTH  first operand; sampled on accept.
- Operand_b  input  WIDTH  second operand / shift amount; sampled on accept.
- Busy  output  1  high whenever the FSM is not in IDLE.
- Done  output  1  one-cycle pulse; results valid from this cycle.
- Result  output  WIDTH  primary result (LO for mult/div).
- Hi  output  WIDTH  HI register: mult upper half, div remainder.
- Zero  output  1  Result == 0.
- Overflow  output  1  signed overflow on add/sub, else 0.
- Div_by_zero  output  1  div with Operand_b == 0.
- Illegal_op  output  1  unrecognised ALU_control.

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; Busy, Done, Result, Hi, Zero, Overflow, Div_by_zero, Illegal_op all 0; iteration counter 0. Reset mid-mult/div aborts the operation; no Done is issued.
- Opcodes:
  - 0000 add, 0001 sub (wrap mod 2^WIDTH).
  - 0010 mult, unsigned, 2*WIDTH product: Hi=upper, Result=lower.
  - 0011 div, unsigned: Result=quotient, Hi=remainder.
  - 0100 sll A by B[SHAMT_W-1:0]; 0101 srl, logical, zero fill.
  - 1000 and, 1001 or, 1010 xor, 1011 nor.
  - Any other code: Result=0, Hi unchanged, Illegal_op=1.
- FSM states: IDLE, ITER, DONE.
  - IDLE: when Start=1, latch operands and opcode at edge T.
    - Single-cycle or illegal op: go to DONE, results registered at the same edge.
    - Mult/div: go to ITER, counter=WIDTH-1.
  - ITER: one bit per cycle; counter decrements; at counter==0 the final step is performed and the FSM goes to DONE. Exactly WIDTH cycles in ITER.
  - DONE: Done=1 for one cycle, then back to IDLE.
- Latency from accept edge T:
  - Single-cycle op: Done high during cycle T+1.
  - Mult/div: Done high during cycle T+WIDTH+1.
  - Next Start can be accepted at the edge ending the DONE cycle+1, i.e. in IDLE only.
- Busy = (state != IDLE). Start while Busy is ignored: no queuing, latched operands unaffected.
- Result, Hi and all flags hold their values until the next Done. Flags are updated only at DONE entry. Zero is evaluated on the final Result.
- Overflow:
  - add: sign(A)==sign(B) and sign(R)!=sign(A).
  - sub: sign(A)!=sign(B) and sign(R)!=sign(A).
  - All other ops: 0.
- Div by zero: skip iteration, go directly IDLE→DONE (single-cycle latency) with Result=all ones, Hi=Operand_a, Div_by_zero=1.
- Shift amount ≥ WIDTH cannot occur (masked to SHAMT_W bits); shift by 0 returns A unchanged.
- Input changes after accept have no effect.

Test Plan:
- Reset then idle → all outputs 0, Busy=0. Assert resetn=0 at cycle 10 of a mult → Busy=0 immediately, no Done pulse.
- add 0x7FFFFFFF+1 → Done at T+1, Result=0x80000000, Overflow=1. sub 5-5 → Result=0, Zero=1, Overflow=0.
- mult 0xFFFFFFFF*0x00000002 → Busy high 33 cycles, Done at T+33, Hi=0x00000001, Result=0xFFFFFFFE. Start pulsed during Busy is ignored.
- div 100/7 → Done at T+33, Result=14, Hi=2. div 9/0 → Done at T+1, Result=0xFFFFFFFF, Hi=9, Div_by_zero=1.
- sll 0x1 by 31 → 0x80000000; srl 0x80000000 by 4 → 0x08000000; nor 0,0 → 0xFFFFFFFF; and/or/xor with 0xF0F0/0x0FF0 → 0x00F0/0xFFF0/0xFF00.
- ALU_control=0111 → Done at T+1, Result=0, Illegal_op=1, Hi retains its previous value. Back-to-back single-cycle ops at maximum rate → one Done every 2 cycles.

Source files
------------

// File: rtl/alu_execute_unit.sv
// alu_execute_unit
//   Execution-stage ALU with a start/busy/done handshake. Add, sub, shifts and
//   logic ops finish in one state step. Mult (shift-add) and div (restoring)
//   iterate one bit per cycle for WIDTH cycles and write HI/LO.
//
// Ports
//   clock, resetn        rising-edge clock, asynchronous active-low reset
//   Start                request, accepted only while Busy = 0
//   ALU_control          4-bit operation code, sampled on accept
//   Operand_a/Operand_b  operands (Operand_b low bits = shift amount)
//   Busy                 FSM is not in IDLE
//   Done                 one-cycle pulse, results valid from this cycle
//   Result, Hi           primary result (LO) and HI register
//   Zero, Overflow, Div_by_zero, Illegal_op   status flags, held until next Done
module alu_execute_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             Start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] Operand_a,
  input  logic [WIDTH-1:0] Operand_b,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             Overflow,
  output logic             Div_by_zero,
  output logic             Illegal_op
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MULT = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [SHAMT_W-1:0] cnt;
  // work_hi: product upper half / partial remainder.
  // work_lo: multiplier shifting out LSB-first / dividend shifting out MSB-first,
  //          with product lower bits / quotient bits shifting in.
  logic [WIDTH-1:0]   work_hi;
  logic [WIDTH-1:0]   work_lo;

  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;
  logic               sc_legal;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;

  assign Busy = (state != S_IDLE);

  // Single-cycle results are computed from the live inputs because they are
  // registered on the same edge that accepts the request.
  always_comb begin
    sc_res   = '0;
    sc_ovf   = 1'b0;
    sc_legal = 1'b1;
    case (ALU_control)
      OP_ADD: begin
        sc_res = Operand_a + Operand_b;
        sc_ovf = (Operand_a[WIDTH-1] == Operand_b[WIDTH-1]) &&
                 (sc_res[WIDTH-1] != Operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = Operand_a - Operand_b;
        sc_ovf = (Operand_a[WIDTH-1] != Operand_b[WIDTH-1]) &&
                 (sc_res[WIDTH-1] != Operand_a[WIDTH-1]);
      end
      OP_MULT, OP_DIV: sc_res = '0;
      OP_SLL:  sc_res = Operand_a << Operand_b[SHAMT_W-1:0];
      OP_SRL:  sc_res = Operand_a >> Operand_b[SHAMT_W-1:0];
      OP_AND:  sc_res = Operand_a & Operand_b;
      OP_OR:   sc_res = Operand_a | Operand_b;
      OP_XOR:  sc_res = Operand_a ^ Operand_b;
      OP_NOR:  sc_res = ~(Operand_a | Operand_b);
      default: sc_legal = 1'b0;
    endcase
  end

  // One iteration step. Mult adds the multiplicand when the current multiplier
  // bit is set, then shifts the (WIDTH+1)-bit sum right into the pair.
  // Div shifts the next dividend bit into the remainder and keeps the
  // difference only when no borrow occurred (restoring division).
  always_comb begin
    mul_sum   = {1'b0, work_hi} + {1'b0, (work_lo[0] ? a_q : '0)};
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q == OP_MULT) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      step_hi = div_diff[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = div_shift[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt         <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
      Done        <= 1'b0;
      Result      <= '0;
      Hi          <= '0;
      Zero        <= 1'b0;
      Overflow    <= 1'b0;
      Div_by_zero <= 1'b0;
      Illegal_op  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q <= ALU_control;
            a_q  <= Operand_a;
            b_q  <= Operand_b;
            if (ALU_control == OP_MULT) begin
              work_hi <= '0;
              work_lo <= Operand_b;
              cnt     <= SHAMT_W'(WIDTH - 1);
              state   <= S_ITER;
            end else if (ALU_control == OP_DIV && Operand_b != '0) begin
              work_hi <= '0;
              work_lo <= Operand_a;
              cnt     <= SHAMT_W'(WIDTH - 1);
              state   <= S_ITER;
            end else if (ALU_control == OP_DIV) begin
              // Divide by zero bypasses the iteration entirely.
              Result      <= '1;
              Hi          <= Operand_a;
              Zero        <= 1'b0;
              Overflow    <= 1'b0;
              Div_by_zero <= 1'b1;
              Illegal_op  <= 1'b0;
              Done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              // Hi is left untouched by single-cycle and illegal ops.
              Result      <= sc_res;
              Zero        <= (sc_res == '0);
              Overflow    <= sc_ovf;
              Div_by_zero <= 1'b0;
              Illegal_op  <= !sc_legal;
              Done        <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_ITER: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          cnt     <= cnt - 1'b1;
          if (cnt == '0) begin
            Result      <= step_lo;
            Hi          <= step_hi;
            Zero        <= (step_lo == '0);
            Overflow    <= 1'b0;
            Div_by_zero <= 1'b0;
            Illegal_op  <= 1'b0;
            Done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// tb_alu_execute_unit
//   Directed self-checking bench for alu_execute_unit (WIDTH = 32).
//   Outputs are sampled on the falling clock edge; inputs are driven there too.
module tb_alu_execute_unit;

  logic        clock;
  logic        resetn;
  logic        Start;
  logic [3:0]  ALU_control;
  logic [31:0] Operand_a;
  logic [31:0] Operand_b;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic [31:0] Hi;
  logic        Zero;
  logic        Overflow;
  logic        Div_by_zero;
  logic        Illegal_op;

  int checks = 0;
  int errors = 0;

  alu_execute_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock(clock), .resetn(resetn), .Start(Start), .ALU_control(ALU_control),
    .Operand_a(Operand_a), .Operand_b(Operand_b), .Busy(Busy), .Done(Done),
    .Result(Result), .Hi(Hi), .Zero(Zero), .Overflow(Overflow),
    .Div_by_zero(Div_by_zero), .Illegal_op(Illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present a request for exactly one accept edge, then scramble the inputs
  // so that any late sampling by the DUT shows up as a wrong result.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    Start = 1'b1; ALU_control = op; Operand_a = a; Operand_b = b;
    @(posedge clock);
    #1;
    Start = 1'b0; ALU_control = 4'b0000; Operand_a = 32'hA5A5_5A5A; Operand_b = 32'h0000_0003;
  endtask

  // Count falling edges after the accept edge until Done (n = 1 means cycle T+1).
  // A Start pulse with different operands is injected at falling edge pulse_at.
  task automatic wait_done(input int pulse_at, output int cycles, output int busy_cnt);
    cycles = -1;
    busy_cnt = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      Start = (n == pulse_at);
      if (n == pulse_at) begin
        ALU_control = 4'b0000; Operand_a = 32'h1; Operand_b = 32'h1;
      end
      if (Busy) busy_cnt++;
      if (Done) begin
        cycles = n;
        break;
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; Start = 1'b0; ALU_control = 4'b0; Operand_a = '0; Operand_b = '0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({Busy, Done, Zero, Overflow, Div_by_zero, Illegal_op} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {Busy, Done, Zero, Overflow, Div_by_zero, Illegal_op});
    end
    checks++;
    if (Result !== 32'h0 || Hi !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got Result=%h Hi=%h expected 0/0", Result, Hi);
    end
  endtask

  task automatic test_add_sub();
    int cyc, bsy;
    start_op(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_done(0, cyc, bsy);
    checks++;
    if (cyc !== 1) begin errors++; $display("[TB] FAIL add_latency: got %0d expected 1", cyc); end
    checks++;
    if ({Result, Overflow, Zero} !== {32'h8000_0000, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL add_ovf: got %h ovf=%b z=%b expected 80000000 ovf=1 z=0", Result, Overflow, Zero);
    end
    start_op(4'b0001, 32'd5, 32'd5);
    wait_done(0, cyc, bsy);
    checks++;
    if ({Result, Overflow, Zero} !== {32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL sub_zero: got %h ovf=%b z=%b expected 0 ovf=0 z=1", Result, Overflow, Zero);
    end
    start_op(4'b0001, 32'h8000_0000, 32'h0000_0001);
    wait_done(0, cyc, bsy);
    checks++;
    if ({Result, Overflow} !== {32'h7FFF_FFFF, 1'b1}) begin
      errors++;
      $display("[TB] FAIL sub_ovf: got %h ovf=%b expected 7fffffff ovf=1", Result, Overflow);
    end
  endtask

  task automatic test_mult();
    int cyc, bsy, extra;
    start_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(5, cyc, bsy);
    checks++;
    if (cyc !== 33) begin errors++; $display("[TB] FAIL mult_latency: got %0d expected 33", cyc); end
    checks++;
    if (bsy !== 33) begin errors++; $display("[TB] FAIL mult_busy: got %0d expected 33", bsy); end
    checks++;
    if ({Hi, Result, Overflow} !== {32'h0000_0001, 32'hFFFF_FFFE, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mult_result: got Hi=%h Lo=%h ovf=%b expected 00000001 fffffffe 0", Hi, Result, Overflow);
    end
    extra = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      if (Done || Busy) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("[TB] FAIL mult_ignored_start: got %0d busy/done cycles expected 0", extra); end
    checks++;
    if (Result !== 32'hFFFF_FFFE) begin
      errors++;
      $display("[TB] FAIL mult_hold: got %h expected fffffffe", Result);
    end
  endtask

  task automatic test_div();
    int cyc, bsy;
    start_op(4'b0011, 32'd100, 32'd7);
    wait_done(0, cyc, bsy);
    checks++;
    if (cyc !== 33) begin errors++; $display("[TB] FAIL div_latency: got %0d expected 33", cyc); end
    checks++;
    if ({Result, Hi, Div_by_zero} !== {32'd14, 32'd2, 1'b0}) begin
      errors++;
      $display("[TB] FAIL div_result: got q=%0d r=%0d dz=%b expected 14 2 0", Result, Hi, Div_by_zero);
    end
    start_op(4'b0011, 32'd9, 32'd0);
    wait_done(0, cyc, bsy);
    checks++;
    if (cyc !== 1) begin errors++; $display("[TB] FAIL div0_latency: got %0d expected 1", cyc); end
    checks++;
    if ({Result, Hi, Div_by_zero, Zero} !== {32'hFFFF_FFFF, 32'd9, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL div0_result: got %h Hi=%h dz=%b z=%b expected ffffffff 9 1 0",
               Result, Hi, Div_by_zero, Zero);
    end
  endtask

  task automatic test_illegal();
    int cyc, bsy;
    start_op(4'b0111, 32'h1234_5678, 32'h1);
    wait_done(0, cyc, bsy);
    checks++;
    if (cyc !== 1) begin errors++; $display("[TB] FAIL illegal_latency: got %0d expected 1", cyc); end
    checks++;
    if ({Result, Hi, Illegal_op, Zero, Div_by_zero} !== {32'h0, 32'd9, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL illegal_result: got %h Hi=%h ill=%b z=%b dz=%b expected 0 9 1 1 0",
               Result, Hi, Illegal_op, Zero, Div_by_zero);
    end
  endtask

  task automatic test_shift_logic();
    logic [3:0]  ops [7]  = '{4'b0100, 4'b0101, 4'b0100, 4'b1011, 4'b1000, 4'b1001, 4'b1010};
    logic [31:0] as  [7]  = '{32'h1, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 32'hF0F0, 32'hF0F0, 32'hF0F0};
    logic [31:0] bs  [7]  = '{32'd31, 32'd4, 32'h20, 32'h0, 32'h0FF0, 32'h0FF0, 32'h0FF0};
    logic [31:0] exp [7]  = '{32'h8000_0000, 32'h0800_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
                              32'h00F0, 32'hFFF0, 32'hFF00};
    int cyc, bsy;
    for (int i = 0; i < 7; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_done(0, cyc, bsy);
      checks++;
      if ({cyc, Result, Illegal_op} !== {32'd1, exp[i], 1'b0}) begin
        errors++;
        $display("[TB] FAIL shift_logic_%0d: got cyc=%0d %h ill=%b expected 1 %h 0",
                 i, cyc, Result, Illegal_op, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses, bad;
    pulses = 0; bad = 0;
    @(negedge clock);
    Start = 1'b1; ALU_control = 4'b0000; Operand_a = 32'd2; Operand_b = 32'd3;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      if (Done) pulses++;
      if (Done !== ((n % 2) == 1)) bad++;
    end
    Start = 1'b0;
    checks++;
    if (pulses !== 5 || bad !== 0) begin
      errors++;
      $display("[TB] FAIL back_to_back: got %0d pulses %0d misplaced expected 5 0", pulses, bad);
    end
    checks++;
    if (Result !== 32'd5) begin errors++; $display("[TB] FAIL back_to_back_result: got %0d expected 5", Result); end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_abort();
    int dones;
    start_op(4'b0010, 32'h0000_0003, 32'h0000_0005);
    repeat (10) @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Result, Hi} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset_abort_async: got busy=%b done=%b %h %h expected 0 0 0 0", Busy, Done, Result, Hi);
    end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (Done || Busy) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("[TB] FAIL reset_abort_nodone: got %0d expected 0", dones); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mult();
    test_div();
    test_illegal();
    test_shift_logic();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
